// File: rtl/expr_vector_sequencer.sv
// expr_vector_sequencer: drives LFSR-generated operand vectors into a
// combinational expression unit, samples its 90-bit result after a fixed
// settle time, folds each result into a 32-bit MISR and returns the
// signature over a valid/ready handshake.
// Optional build macro EXPR_SEQ_TRACE_EN adds a per-vector trace port with
// back-pressure; without it every CAPTURE completes in a single cycle.
module expr_vector_sequencer #(
  parameter int unsigned EVAL_LAT  = 1,
  parameter int unsigned CNT_W     = 16,
  parameter logic [63:0] DFLT_SEED = 64'h1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [63:0]        seed,
  input  logic [CNT_W-1:0]   num_vec,
  output logic               busy,
  output logic [3:0]         a0,
  output logic [4:0]         a1,
  output logic [5:0]         a2,
  output logic signed [3:0]  a3,
  output logic signed [4:0]  a4,
  output logic signed [5:0]  a5,
  output logic [3:0]         b0,
  output logic [4:0]         b1,
  output logic [5:0]         b2,
  output logic signed [3:0]  b3,
  output logic signed [4:0]  b4,
  output logic signed [5:0]  b5,
  input  logic [89:0]        y_in,
  output logic               sig_valid,
  input  logic               sig_ready,
  output logic [31:0]        sig,
`ifdef EXPR_SEQ_TRACE_EN
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [89:0]        trace_y,
  output logic [CNT_W-1:0]   trace_idx,
`endif
  output logic [CNT_W-1:0]   vec_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [3:0]  SETTLE_INIT = 4'(EVAL_LAT - 1);
  localparam logic [63:0] LFSR_TAPS   = 64'hD800_0000_0000_0000;
  localparam logic [31:0] MISR_POLY   = 32'h04C1_1DB7;

  state_t             state;
  logic [63:0]        lfsr;
  logic [31:0]        misr;
  logic [CNT_W-1:0]   num_lat;
  logic [3:0]         settle;

  logic [63:0]        lfsr_nx;
  logic [31:0]        fold;
  logic [31:0]        misr_nx;
  logic [CNT_W-1:0]   cnt_nx;
  logic               capture_go;

  // Next-state arithmetic for LFSR, MISR fold and vector counter
  always_comb begin
    lfsr_nx = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 64'h0);
    fold    = y_in[31:0] ^ y_in[63:32] ^ {6'b0, y_in[89:64]};
    misr_nx = {misr[30:0], 1'b0} ^ (misr[31] ? MISR_POLY : 32'h0) ^ fold;
    cnt_nx  = vec_cnt + 1'b1;
  end

  // CAPTURE may only complete once any trace consumer has taken the vector
  always_comb begin
    capture_go = 1'b1;
`ifdef EXPR_SEQ_TRACE_EN
    capture_go = trace_ready;
`endif
  end

`ifdef EXPR_SEQ_TRACE_EN
  // Operands are frozen while in CAPTURE, so y_in is stable for the trace
  assign trace_y = y_in;
`endif

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lfsr      <= DFLT_SEED;
      misr      <= '0;
      num_lat   <= '0;
      settle    <= '0;
      vec_cnt   <= '0;
      busy      <= 1'b0;
      sig_valid <= 1'b0;
      sig       <= '0;
      {b5, b4, b3, b2, b1, b0, a5, a4, a3, a2, a1, a0} <= '0;
`ifdef EXPR_SEQ_TRACE_EN
      trace_valid <= 1'b0;
      trace_idx   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lfsr    <= (seed == 64'h0) ? DFLT_SEED : seed;
            misr    <= '0;
            vec_cnt <= '0;
            num_lat <= num_vec;
            busy    <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          {b5, b4, b3, b2, b1, b0, a5, a4, a3, a2, a1, a0} <= lfsr[59:0];
          settle <= SETTLE_INIT;
          if (num_lat == '0) begin
            sig       <= misr;
            sig_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle == '0) begin
            state <= S_CAPTURE;
`ifdef EXPR_SEQ_TRACE_EN
            trace_valid <= 1'b1;
            trace_idx   <= vec_cnt;
`endif
          end else begin
            settle <= settle - 1'b1;
          end
        end
        S_CAPTURE: begin
          if (capture_go) begin
            misr    <= misr_nx;
            vec_cnt <= cnt_nx;
            lfsr    <= lfsr_nx;
`ifdef EXPR_SEQ_TRACE_EN
            trace_valid <= 1'b0;
`endif
            // Signature is registered on the same edge as the final fold
            if (cnt_nx == num_lat) begin
              sig       <= misr_nx;
              sig_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          if (sig_ready) begin
            sig_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Directed self-checking bench for expr_vector_sequencer (EVAL_LAT=3).
module tb_expr_vector_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [63:0]        seed;
  logic [15:0]        num_vec;
  logic               busy;
  logic [3:0]         a0, b0;
  logic [4:0]         a1, b1;
  logic [5:0]         a2, b2;
  logic signed [3:0]  a3, b3;
  logic signed [4:0]  a4, b4;
  logic signed [5:0]  a5, b5;
  logic [89:0]        y_in;
  logic               sig_valid;
  logic               sig_ready;
  logic [31:0]        sig;
  logic [15:0]        vec_cnt;
`ifdef EXPR_SEQ_TRACE_EN
  logic               trace_valid;
  logic               trace_ready = 1'b1;
  logic [89:0]        trace_y;
  logic [15:0]        trace_idx;
`endif

  logic               expr_mode;
  logic [89:0]        y_fix;
  logic [59:0]        dut_ops;
  int                 checks = 0;
  int                 failures = 0;

  always #5 clk = ~clk;

  // Stand-in expression unit: a fixed pattern or a function of the operands
  assign dut_ops = {b5, b4, b3, b2, b1, b0, a5, a4, a3, a2, a1, a0};
  assign y_in    = expr_mode ? {~dut_ops[29:0], dut_ops} : y_fix;

  expr_vector_sequencer #(.EVAL_LAT(3), .CNT_W(16), .DFLT_SEED(64'h1)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .num_vec(num_vec),
    .busy(busy),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5),
    .y_in(y_in), .sig_valid(sig_valid), .sig_ready(sig_ready), .sig(sig),
`ifdef EXPR_SEQ_TRACE_EN
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_y(trace_y), .trace_idx(trace_idx),
`endif
    .vec_cnt(vec_cnt)
  );

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return (l >> 1) ^ (l[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  function automatic logic [31:0] model_sig(input logic [63:0] s, input int unsigned n);
    logic [63:0] l;
    logic [31:0] m;
    logic [89:0] y;
    logic [31:0] f;
    l = (s == 64'h0) ? 64'h1 : s;
    m = 32'h0;
    for (int unsigned i = 0; i < n; i++) begin
      y = {~l[29:0], l[59:0]};
      f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
      m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C1_1DB7 : 32'h0) ^ f;
      l = lfsr_step(l);
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] s, input logic [15:0] n);
    seed    = s;
    num_vec = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    int took;
    took = 0;
    while (!sig_valid && took < maxc) begin
      tick();
      took++;
    end
    checks++;
    if (sig_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_valid: sig_valid=%b after %0d cycles, required 1", sig_valid, took);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sig_valid !== 1'b0) begin failures++; $display("FAIL reset_sig_valid got=%b exp=0", sig_valid); end
    checks++; if (sig !== 32'h0) begin failures++; $display("FAIL reset_sig got=%h exp=0", sig); end
    checks++; if (vec_cnt !== 16'h0) begin failures++; $display("FAIL reset_vec_cnt got=%h exp=0", vec_cnt); end
    checks++; if (dut_ops !== 60'h0) begin failures++; $display("FAIL reset_ops got=%h exp=0", dut_ops); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_y();
    expr_mode = 1'b0;
    y_fix     = '0;
    sig_ready = 1'b1;
    do_start(64'h1, 16'd1);
    tick();
    checks++; if (dut_ops !== 60'h1) begin failures++; $display("FAIL zero_y_ops got=%h exp=%h", dut_ops, 60'h1); end
    checks++; if (a0 !== 4'h1) begin failures++; $display("FAIL zero_y_a0 got=%h exp=1", a0); end
    wait_valid(20);
    checks++; if (sig !== 32'h0) begin failures++; $display("FAIL zero_y_sig got=%h exp=0", sig); end
    checks++; if (vec_cnt !== 16'd1) begin failures++; $display("FAIL zero_y_vec_cnt got=%0d exp=1", vec_cnt); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_y_busy_end got=%b exp=0", busy); end
    sig_ready = 1'b0;
  endtask

  task automatic test_ones();
    expr_mode = 1'b0;
    y_fix     = '1;
    sig_ready = 1'b0;
    do_start(64'h1, 16'd1);
    wait_valid(20);
    checks++; if (sig !== 32'h03FF_FFFF) begin failures++; $display("FAIL ones_sig got=%h exp=03ffffff", sig); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ones_busy_done got=%b exp=1", busy); end
    sig_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ones_busy_after_ready got=%b exp=0", busy); end
    checks++; if (sig_valid !== 1'b0) begin failures++; $display("FAIL ones_valid_after_ready got=%b exp=0", sig_valid); end
    sig_ready = 1'b0;
  endtask

  task automatic test_zero_vec();
    logic [63:0] s;
    logic [59:0] exp_ops;
    s       = 64'h0123_4567_89AB_CDEF;
    exp_ops = s[59:0];
    do_start(s, 16'd0);
    tick();
    checks++; if (sig_valid !== 1'b1) begin failures++; $display("FAIL zero_vec_valid got=%b exp=1", sig_valid); end
    checks++; if (sig !== 32'h0) begin failures++; $display("FAIL zero_vec_sig got=%h exp=0", sig); end
    checks++; if (vec_cnt !== 16'd0) begin failures++; $display("FAIL zero_vec_cnt got=%0d exp=0", vec_cnt); end
    checks++; if (dut_ops !== exp_ops) begin failures++; $display("FAIL zero_vec_ops got=%h exp=%h", dut_ops, exp_ops); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (dut_ops !== exp_ops) begin failures++; $display("FAIL zero_vec_ops_hold got=%h exp=%h", dut_ops, exp_ops); end
    sig_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_vec_busy_end got=%b exp=0", busy); end
    sig_ready = 1'b0;
  endtask

  task automatic test_sequence();
    logic [63:0] l;
    logic [59:0] exp_ops [4];
    logic [31:0] exp_sig;
    int          k;
    l = 64'h1;
    for (int i = 0; i < 4; i++) begin
      exp_ops[i] = l[59:0];
      l = lfsr_step(l);
    end
    exp_sig   = model_sig(64'h0, 4);
    expr_mode = 1'b1;
    sig_ready = 1'b0;
    do_start(64'h0, 16'd4);
    for (int n = 1; n <= 21; n++) begin
      tick();
      k = (n - 1) / 5;
      if (k > 3) k = 3;
      checks++;
      if (dut_ops !== exp_ops[k]) begin
        failures++;
        $display("FAIL seq_ops cycle=%0d got=%h exp=%h", n, dut_ops, exp_ops[k]);
      end
      if (n == 6) begin
        checks++; if (vec_cnt !== 16'd1) begin failures++; $display("FAIL seq_vec_cnt_mid got=%0d exp=1", vec_cnt); end
      end
      if (n == 8) begin
        seed = 64'h5; num_vec = 16'd9; start = 1'b1;
      end
      if (n == 9) start = 1'b0;
      if (n == 19) begin
        checks++; if (sig_valid !== 1'b0) begin failures++; $display("FAIL seq_valid_early got=%b exp=0", sig_valid); end
      end
      if (n == 20) begin
        checks++; if (sig_valid !== 1'b1) begin failures++; $display("FAIL seq_valid_on_time got=%b exp=1", sig_valid); end
        checks++; if (sig !== exp_sig) begin failures++; $display("FAIL seq_sig got=%h exp=%h", sig, exp_sig); end
        checks++; if (vec_cnt !== 16'd4) begin failures++; $display("FAIL seq_vec_cnt got=%0d exp=4", vec_cnt); end
      end
    end
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
  endtask

  task automatic test_hold();
    logic [31:0] exp_sig;
    exp_sig   = model_sig(64'hDEAD_BEEF_0000_1234, 3);
    expr_mode = 1'b1;
    sig_ready = 1'b0;
    do_start(64'hDEAD_BEEF_0000_1234, 16'd3);
    wait_valid(40);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (sig !== exp_sig || sig_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable cycle=%0d got sig=%h valid=%b exp sig=%h valid=1", i, sig, sig_valid, exp_sig);
      end
      tick();
    end
    sig_ready = 1'b1;
    tick();
    checks++; if (sig_valid !== 1'b0) begin failures++; $display("FAIL hold_valid_release got=%b exp=0", sig_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy_release got=%b exp=0", busy); end
    sig_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] s;
    logic [31:0] exp_sig;
    s         = 64'h0000_00F0_0F00_A5A5;
    exp_sig   = model_sig(s, 3);
    expr_mode = 1'b1;
    sig_ready = 1'b0;
    do_start(s, 16'd3);
    for (int i = 0; i < 7; i++) tick();
    checks++; if (vec_cnt !== 16'd1) begin failures++; $display("FAIL mid_vec_cnt_pre got=%0d exp=1", vec_cnt); end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || sig_valid !== 1'b0 || sig !== 32'h0 || vec_cnt !== 16'h0 || dut_ops !== 60'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs got busy=%b valid=%b sig=%h cnt=%h ops=%h exp all zero",
               busy, sig_valid, sig, vec_cnt, dut_ops);
    end
    reset = 1'b0;
    tick();
    do_start(s, 16'd3);
    wait_valid(60);
    checks++; if (sig !== exp_sig) begin failures++; $display("FAIL mid_rerun_sig got=%h exp=%h", sig, exp_sig); end
    checks++; if (vec_cnt !== 16'd3) begin failures++; $display("FAIL mid_rerun_cnt got=%0d exp=3", vec_cnt); end
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    seed      = '0;
    num_vec   = '0;
    sig_ready = 1'b0;
    expr_mode = 1'b0;
    y_fix     = '0;
    test_reset();
    test_zero_y();
    test_ones();
    test_zero_vec();
    test_sequence();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
